// File: rtl/dwa_dem_encoder.sv
// Dynamic-element-matching encoder: maps each quantizer code to a set of
// unit-element enables (thermometer, DWA or LFSR-dithered DWA).
//
// Ports:
//   clk, rst        : rising-edge clock, async active-high reset
//   clr             : sync clear of rotation pointer and dither LFSR
//   mode            : 0 thermometer, 1/3 DWA, 2 dithered DWA
//   in_valid/in_code: quantizer sample (always consumed)
//   out_valid       : out_sel/sat updated this cycle
//   out_sel         : unit-element enables, bit i drives element i
//   ptr             : current rotation pointer
//   sat             : last accepted code exceeded NUM_ELEM
module dwa_dem_encoder #(
  parameter int CODE_WIDTH = 3,
  parameter int NUM_ELEM   = 7,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEM),
  parameter int LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 8'hFF,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  input  logic [CODE_WIDTH-1:0] in_code,
  output logic                  out_valid,
  output logic [NUM_ELEM-1:0]   out_sel,
  output logic [PTR_WIDTH-1:0]  ptr,
  output logic                  sat
);

  // Sum width: ptr + count + dither never exceeds 2*NUM_ELEM.
  localparam int SW = PTR_WIDTH + 2;
  localparam int XW = (CODE_WIDTH > SW) ? CODE_WIDTH : SW;
  localparam logic [SW-1:0] NE_S = SW'(NUM_ELEM);
  localparam logic [XW-1:0] NE_X = XW'(NUM_ELEM);

  typedef enum logic [1:0] {
    M_THERM = 2'd0,
    M_DWA   = 2'd1,
    M_DITH  = 2'd2,
    M_ALT   = 2'd3
  } mode_e;

  logic                  out_valid_q, out_valid_d;
  logic [NUM_ELEM-1:0]   out_sel_q, out_sel_d;
  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  sat_q, sat_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  logic [XW-1:0]         code_x;
  logic                  over;
  logic [SW-1:0]         cnt;
  logic [PTR_WIDTH-1:0]  ptr_base;
  logic [LFSR_WIDTH-1:0] lfsr_base;
  logic [LFSR_WIDTH-1:0] lfsr_step;
  logic                  fb;
  logic                  dith;
  logic [NUM_ELEM-1:0]   therm;
  logic [2*NUM_ELEM-1:0] rot;
  logic [NUM_ELEM-1:0]   rot_sel;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         mod1;
  logic [SW-1:0]         mod2;
  mode_e                 mode_m;

  always_comb begin
    code_x = XW'(in_code);
    over   = code_x > NE_X;
    cnt    = over ? NE_S : SW'(code_x);

    // A clear alongside a sample encodes from the reset state.
    ptr_base  = clr ? '0 : ptr_q;
    lfsr_base = clr ? LFSR_SEED : lfsr_q;

    fb        = ^(lfsr_base & LFSR_TAPS);
    lfsr_step = {lfsr_base[LFSR_WIDTH-2:0], fb};
    mode_m    = mode_e'(mode);
    dith      = (mode_m == M_DITH) ? lfsr_base[0] : 1'b0;

    therm = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      therm[i] = SW'(i) < cnt;
    end

    // Rotate-left by ptr: upper half of the doubled word wraps the run.
    rot     = {therm, therm} << ptr_base;
    rot_sel = rot[2*NUM_ELEM-1:NUM_ELEM];

    sum  = SW'(ptr_base) + cnt + SW'(dith);
    mod1 = (sum >= NE_S) ? sum - NE_S : sum;
    mod2 = (mod1 >= NE_S) ? mod1 - NE_S : mod1;
  end

  always_comb begin
    out_valid_d = in_valid;
    out_sel_d   = out_sel_q;
    sat_d       = sat_q;
    ptr_d       = ptr_base;
    lfsr_d      = lfsr_base;
    if (in_valid) begin
      sat_d = over;
      unique case (mode_m)
        M_THERM: begin
          out_sel_d = therm;
        end
        M_DITH: begin
          out_sel_d = rot_sel;
          ptr_d     = mod2[PTR_WIDTH-1:0];
          lfsr_d    = lfsr_step;
        end
        M_DWA, M_ALT: begin
          out_sel_d = rot_sel;
          ptr_d     = mod2[PTR_WIDTH-1:0];
        end
        default: begin
          out_sel_d = rot_sel;
          ptr_d     = mod2[PTR_WIDTH-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
      sat_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
      sat_q       <= sat_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign ptr       = ptr_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dwa_dem_encoder.sv
// Self-checking bench for dwa_dem_encoder (CODE_WIDTH=4, NUM_ELEM=7).
// Expected outputs are queued when a sample is driven and popped on output.
module tb_dwa_dem_encoder;

  localparam int CW = 4;
  localparam int NE = 7;
  localparam int PW = 3;
  localparam logic [7:0] SEED = 8'hFF;
  localparam logic [7:0] TAPS = 8'hB8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [1:0]    mode;
  logic          in_valid;
  logic [CW-1:0] in_code;
  logic          out_valid;
  logic [NE-1:0] out_sel;
  logic [PW-1:0] ptr;
  logic          sat;

  always #5 clk = ~clk;

  dwa_dem_encoder #(
    .CODE_WIDTH(CW),
    .NUM_ELEM(NE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .mode(mode),
    .in_valid(in_valid),
    .in_code(in_code),
    .out_valid(out_valid),
    .out_sel(out_sel),
    .ptr(ptr),
    .sat(sat)
  );

  typedef struct packed {
    logic [NE-1:0] sel;
    logic [PW-1:0] ptr;
    logic          sat;
  } exp_t;

  exp_t       q[$];
  exp_t       m_last;
  int         m_ptr;
  logic [7:0] m_lfsr;
  int         errs = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    m_ptr  = 0;
    m_lfsr = SEED;
    m_last = '0;
    q.delete();
  endtask

  task automatic model(input logic c, input logic [1:0] m, input int code);
    int   cnt;
    int   d;
    int   b;
    logic f;
    exp_t e;
    if (c) begin
      m_ptr  = 0;
      m_lfsr = SEED;
    end
    cnt = (code > NE) ? NE : code;
    d = 0;
    e = '0;
    for (int i = 0; i < NE; i++) begin
      b = (m == 2'd0) ? i : (i - m_ptr + NE) % NE;
      if (b < cnt) e.sel[i] = 1'b1;
    end
    if (m == 2'd2) begin
      d = int'(m_lfsr[0]);
      f = 1'b0;
      for (int k = 0; k < 8; k++)
        if (TAPS[k]) f = f ^ m_lfsr[k];
      m_lfsr = {m_lfsr[6:0], f};
    end
    if (m != 2'd0) m_ptr = (m_ptr + cnt + d) % NE;
    e.ptr = PW'(m_ptr);
    e.sat = code > NE;
    m_last = e;
    q.push_back(e);
  endtask

  task automatic step(input logic c, input logic [1:0] m,
                      input logic v, input int code);
    exp_t e;
    @(negedge clk);
    clr = c;
    mode = m;
    in_valid = v;
    in_code = CW'(code);
    if (v) begin
      model(c, m, code);
    end else if (c) begin
      m_ptr = 0;
      m_lfsr = SEED;
      m_last.ptr = '0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sel", 32'(out_sel), 32'(e.sel));
        chk("ptr", 32'(ptr), 32'(e.ptr));
        chk("sat", 32'(sat), 32'(e.sat));
      end
    end else begin
      chk("hold_sel", 32'(out_sel), 32'(m_last.sel));
      chk("hold_ptr", 32'(ptr), 32'(m_last.ptr));
      chk("hold_sat", 32'(sat), 32'(m_last.sat));
    end
    clr = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_code = CW'(5);
    mode = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    model_rst();
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    mode = 2'd1;
    in_valid = 1'b0;
    in_code = '0;
    model_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("init_sel", 32'(out_sel), 32'd0);
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_ptr", 32'(ptr), 32'd0);
    chk("init_lfsr", 32'(u_dut.lfsr_q), 32'(SEED));
    @(negedge clk);
    rst = 1'b0;

    step(1'b0, 2'd1, 1'b1, 3);
    chk("tp2a", 32'(out_sel), 32'b0000111);
    step(1'b0, 2'd1, 1'b1, 3);
    chk("tp2b", 32'(out_sel), 32'b0111000);
    chk("tp2b_ptr", 32'(ptr), 32'd6);
    step(1'b0, 2'd1, 1'b1, 3);
    chk("tp2c", 32'(out_sel), 32'b1000011);
    chk("tp2c_ptr", 32'(ptr), 32'd2);

    step(1'b0, 2'd1, 1'b1, 9);
    chk("tp4_sel", 32'(out_sel), 32'b1111111);
    chk("tp4_sat", 32'(sat), 32'd1);
    chk("tp4_ptr", 32'(ptr), 32'd2);
    step(1'b0, 2'd1, 1'b1, 0);
    chk("tp4_zero", 32'(out_sel), 32'd0);
    chk("tp4_unsat", 32'(sat), 32'd0);

    step(1'b0, 2'd1, 1'b1, 2);
    step(1'b0, 2'd0, 1'b1, 5);
    chk("tp3a", 32'(out_sel), 32'b0011111);
    chk("tp3a_ptr", 32'(ptr), 32'd4);
    step(1'b0, 2'd0, 1'b1, 2);
    chk("tp3b", 32'(out_sel), 32'b0000011);

    step(1'b0, 2'd1, 1'b1, 1);
    chk("tp6_pre", 32'(ptr), 32'd5);
    step(1'b1, 2'd1, 1'b1, 4);
    chk("tp6_sel", 32'(out_sel), 32'b0001111);
    chk("tp6_ptr", 32'(ptr), 32'd4);
    step(1'b0, 2'd1, 1'b0, 0);
    step(1'b0, 2'd2, 1'b0, 6);
    step(1'b0, 2'd3, 1'b1, 6);
    step(1'b1, 2'd1, 1'b0, 0);
    chk("clr_only", 32'(ptr), 32'd0);

    mid_reset();
    step(1'b0, 2'd1, 1'b1, 3);
    chk("tp1", 32'(out_sel), 32'b0000111);

    mid_reset();
    step(1'b0, 2'd2, 1'b1, 2);
    chk("tp5a", 32'(out_sel), 32'b0000011);
    chk("tp5a_ptr", 32'(ptr), 32'd3);
    chk("tp5a_lfsr", 32'(u_dut.lfsr_q), 32'hFE);
    step(1'b0, 2'd2, 1'b1, 2);
    chk("tp5b", 32'(out_sel), 32'b0011000);
    chk("tp5b_ptr", 32'(ptr), 32'd5);
    step(1'b0, 2'd2, 1'b1, 0);

    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 15)));
    end
    chk("lfsr_end", 32'(u_dut.lfsr_q), 32'(m_lfsr));
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dwa_dem_encoder.md
# dwa_dem_encoder

Parametrised dynamic-element-matching encoder. It sits between the multi-bit quantizer and the unit-element DAC array. Each accepted quantizer code N is mapped to N of NUM_ELEM unit elements, with three modes: plain thermometer, data-weighted averaging (rotating pointer), and LFSR-dithered DWA. It generalises the fixed switching block to arbitrary element count and code width, and adds pointer state, saturation and mode control.

## Interface
- CODE_WIDTH, 3: quantizer code width.
- NUM_ELEM, 7: number of unit elements; legal range 2..(1<<CODE_WIDTH)-1 or larger.
- PTR_WIDTH, $clog2(NUM_ELEM): pointer width (derived).
- LFSR_WIDTH, 8: dither LFSR width.
- LFSR_SEED, 8'hFF: LFSR reset/clear value. Must be non-zero.
- LFSR_TAPS, 8'hB8: Fibonacci tap mask (x^8+x^6+x^5+x^4+1).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous clear of pointer and LFSR.
- mode, input, 2: 0 = thermometer, 1 = DWA, 2 = dithered DWA, 3 = treated as 1.
- in_valid, input, 1: in_code is valid this cycle.
- in_code, input, CODE_WIDTH: requested number of active elements.
- out_valid, output, 1: out_sel updated this cycle.
- out_sel, output, NUM_ELEM: unit-element enables, bit i drives element i.
- ptr, output, PTR_WIDTH: current rotation pointer.
- sat, output, 1: the last accepted code exceeded NUM_ELEM.

## Operation
- Accepted sample: in_valid=1 on a rising clk. There is no backpressure; every valid sample is consumed.
- Effective count: c = min(in_code, NUM_ELEM). sat is registered as (in_code > NUM_ELEM) on each accepted sample.
- Mode 0: out_sel bits 0..c-1 are set. ptr holds its value; the LFSR does not step.
- Mode 1: out_sel sets bits ptr, ptr+1, ..., ptr+c-1, all mod NUM_ELEM. ptr_next = (ptr + c) mod NUM_ELEM. The LFSR does not step.
- Mode 2: selection is the same as mode 1. ptr_next = (ptr + c + d) mod NUM_ELEM, where d = lfsr[0] before the step. The LFSR steps once per accepted sample.
- Modulo arithmetic:
  - The sum s ≤ 2·NUM_ELEM.
  - Compute s at width PTR_WIDTH+2.
  - Conditionally subtract NUM_ELEM twice.
  - The result is always < NUM_ELEM.
- c = 0 gives out_sel = 0. In mode 2, ptr still advances by d.
- c = NUM_ELEM gives out_sel all ones. In mode 1, ptr is unchanged.
- LFSR step:
  - fb = XOR of lfsr bits selected by LFSR_TAPS.
  - lfsr = {lfsr[LFSR_WIDTH-2:0], fb}.
- Mode change applies to the next accepted sample. ptr is kept across mode changes; it is not reset.
- clr=1:
  - ptr goes to 0 and lfsr to LFSR_SEED.
  - If in_valid is also 1, the sample is encoded with ptr=0 and d=LFSR_SEED[0].
  - ptr then updates from 0, and the LFSR steps from the seed per mode.
- in_valid=0: out_valid=0. out_sel, ptr, sat and lfsr all hold.

## Timing
- Latency is one cycle. A sample accepted at edge k sets out_sel/sat and out_valid=1 after edge k. The updated ptr is visible after the same edge.
- Back-to-back valid samples give one output per cycle, with full throughput.
- Reset values: out_sel=0, out_valid=0, ptr=0, sat=0, lfsr=LFSR_SEED.
- rst asserted mid-stream clears all state immediately (asynchronous). The sample in flight is dropped. The first valid sample after release encodes from ptr=0.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
1. Reset: assert rst mid-stream -> out_sel=0, out_valid=0, ptr=0, sat=0 immediately. The first valid code 3 after release (mode 1) -> out_sel=7'b0000111.
2. Mode 1, codes 3,3,3 from ptr 0 -> out_sel 7'b0000111, 7'b0111000, 7'b1000011; ptr 3, 6, 2.
3. Mode 0, codes 5,2 after ptr=4 -> out_sel 7'b0011111 then 7'b0000011; ptr stays 4.
4. CODE_WIDTH=4, mode 1, ptr=2, code 9 -> out_sel all ones, sat=1, ptr stays 2. A following code 0 -> out_sel=0, sat=0.
5. Mode 2 from reset (lfsr=8'hFF), codes 2,2:
   - First -> out_sel 7'b0000011, ptr 3 (d=1), lfsr 8'hFE.
   - Second -> out_sel 7'b0011000, ptr 5 (d=0).
6. clr together with in_valid, code 4, ptr=5, mode 1 -> out_sel 7'b0001111, ptr 4. Gaps in in_valid -> out_valid=0 and outputs hold.
